// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and a buffered MCU result
// stream, with forced MCU drains on starvation and RAW hazard flagging for queued results.
module wb_port_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pipe_valid,
    input  logic [ADDR_W-1:0] i_pipe_rd,
    input  logic [DATA_W-1:0] i_pipe_wdata,
    output logic              o_pipe_stall,
    input  logic              i_mcu_valid,
    output logic              o_mcu_ready,
    input  logic [ADDR_W-1:0] i_mcu_rd,
    input  logic [DATA_W-1:0] i_mcu_wdata,
    input  logic [ADDR_W-1:0] i_query_rs1,
    input  logic [ADDR_W-1:0] i_query_rs2,
    output logic              o_mcu_hazard,
    output logic              o_rf_we,
    output logic [ADDR_W-1:0] o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0] r_fifo_rd   [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [PTR_W:0]    r_wptr;
    logic [PTR_W:0]    r_rptr;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_empty;
    logic              w_full;
    logic [PTR_W:0]    w_count;
    logic              w_push;
    logic              w_force;
    logic              w_grant_fifo;
    logic              w_grant_pipe;
    logic [ADDR_W-1:0] w_head_rd;
    logic [DATA_W-1:0] w_head_data;
    logic              w_hazard;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_count = r_wptr - r_rptr;
    assign w_push  = i_mcu_valid && !w_full;

    assign w_force      = !w_empty && (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    assign w_grant_fifo = w_force || (!i_pipe_valid && !w_empty);
    assign w_grant_pipe = !w_force && i_pipe_valid;
    assign w_head_rd    = r_fifo_rd[r_rptr[PTR_W-1:0]];
    assign w_head_data  = r_fifo_data[r_rptr[PTR_W-1:0]];

    always_comb begin
        logic [PTR_W-1:0] idx;
        w_hazard = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = r_rptr[PTR_W-1:0] + PTR_W'(k);
            if (((PTR_W+1)'(k) < w_count) && (r_fifo_rd[idx] != '0) &&
                ((r_fifo_rd[idx] == i_query_rs1) || (r_fifo_rd[idx] == i_query_rs2))) begin
                w_hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr[PTR_W-1:0]]   <= i_mcu_rd;
            r_fifo_data[r_wptr[PTR_W-1:0]] <= i_mcu_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_starve_cnt <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_grant_fifo) begin
                r_rptr <= r_rptr + 1'b1;
            end

            if (w_grant_fifo || w_empty) begin
                r_starve_cnt <= '0;
            end else if (w_grant_pipe && (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            // rd == 0 still consumes the slot but never writes.
            if (w_grant_fifo) begin
                r_rf_we    <= (w_head_rd != '0);
                r_rf_waddr <= w_head_rd;
                r_rf_wdata <= w_head_data;
            end else if (w_grant_pipe) begin
                r_rf_we    <= (i_pipe_rd != '0);
                r_rf_waddr <= i_pipe_rd;
                r_rf_wdata <= i_pipe_wdata;
            end else begin
                r_rf_we    <= 1'b0;
            end
        end
    end

    assign o_pipe_stall = w_force && i_pipe_valid;
    assign o_mcu_ready  = !w_full;
    assign o_mcu_hazard = w_hazard;
    assign o_rf_we      = r_rf_we;
    assign o_rf_waddr   = r_rf_waddr;
    assign o_rf_wdata   = r_rf_wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts combinational
// outputs each cycle and the write port one cycle later; a negedge monitor compares.
module tb_wb_port_arbiter;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ADDR_W       = 5;
    localparam int unsigned DEPTH        = 2;
    localparam int unsigned STARVE_LIMIT = 4;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef struct {
        logic stall;
        logic ready;
        logic hazard;
    } comb_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_rd;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_stall;
    logic              mcu_valid;
    logic              mcu_ready;
    logic [ADDR_W-1:0] mcu_rd;
    logic [DATA_W-1:0] mcu_wdata;
    logic [ADDR_W-1:0] query_rs1;
    logic [ADDR_W-1:0] query_rs2;
    logic              mcu_hazard;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pipe_valid (pipe_valid),
        .i_pipe_rd    (pipe_rd),
        .i_pipe_wdata (pipe_wdata),
        .o_pipe_stall (pipe_stall),
        .i_mcu_valid  (mcu_valid),
        .o_mcu_ready  (mcu_ready),
        .i_mcu_rd     (mcu_rd),
        .i_mcu_wdata  (mcu_wdata),
        .i_query_rs1  (query_rs1),
        .i_query_rs2  (query_rs2),
        .o_mcu_hazard (mcu_hazard),
        .o_rf_we      (rf_we),
        .o_rf_waddr   (rf_waddr),
        .o_rf_wdata   (rf_wdata)
    );

    // Reference model state
    entry_t m_fifo[$];
    int     m_starve;
    wr_t    m_port;
    wr_t    pending;
    bit     have_pending;

    comb_t  q_comb[$];
    wr_t    q_wr[$];
    comb_t  mon_c;
    wr_t    mon_w;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (q_comb.size() > 0) begin
                mon_c = q_comb.pop_front();
                chk("pipe_stall", DATA_W'(pipe_stall), DATA_W'(mon_c.stall));
                chk("mcu_ready", DATA_W'(mcu_ready), DATA_W'(mon_c.ready));
                chk("mcu_hazard", DATA_W'(mcu_hazard), DATA_W'(mon_c.hazard));
            end
            if (q_wr.size() > 0) begin
                mon_w = q_wr.pop_front();
                chk("rf_we", DATA_W'(rf_we), DATA_W'(mon_w.we));
                chk("rf_waddr", DATA_W'(rf_waddr), DATA_W'(mon_w.addr));
                chk("rf_wdata", rf_wdata, mon_w.data);
            end
        end
    end

    // One clock of stimulus; the model predicts from the arbitration rules.
    task automatic drive(input logic pv, input logic [ADDR_W-1:0] prd,
                         input logic [DATA_W-1:0] pdata, input logic mv,
                         input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] mdata,
                         input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                         output logic stall, output logic pushed);
        comb_t c;
        wr_t   nxt;
        bit    force_g;
        bit    take_fifo;
        bit    take_pipe;
        @(posedge clk);
        #1;
        if (have_pending) q_wr.push_back(pending);
        pipe_valid = pv;
        pipe_rd    = prd;
        pipe_wdata = pdata;
        mcu_valid  = mv;
        mcu_rd     = mrd;
        mcu_wdata  = mdata;
        query_rs1  = rs1;
        query_rs2  = rs2;

        c.ready  = (m_fifo.size() < DEPTH);
        c.hazard = 1'b0;
        foreach (m_fifo[i]) begin
            if (m_fifo[i].rd != 0 && (m_fifo[i].rd == rs1 || m_fifo[i].rd == rs2))
                c.hazard = 1'b1;
        end
        force_g = (m_fifo.size() > 0) && (m_starve == STARVE_LIMIT);
        c.stall = force_g && pv;
        q_comb.push_back(c);

        take_fifo = force_g || (!pv && m_fifo.size() > 0);
        take_pipe = pv && !force_g;
        nxt    = m_port;
        nxt.we = 1'b0;
        if (take_fifo) begin
            nxt.we   = (m_fifo[0].rd != 0);
            nxt.addr = m_fifo[0].rd;
            nxt.data = m_fifo[0].data;
        end else if (take_pipe) begin
            nxt.we   = (prd != 0);
            nxt.addr = prd;
            nxt.data = pdata;
        end
        if (take_fifo || m_fifo.size() == 0) m_starve = 0;
        else if (m_starve < STARVE_LIMIT) m_starve++;
        if (take_fifo) void'(m_fifo.pop_front());
        pushed = mv && c.ready;
        if (pushed) m_fifo.push_back('{rd: mrd, data: mdata});
        m_port       = nxt;
        pending      = nxt;
        have_pending = 1'b1;
        stall        = c.stall;
    endtask

    task automatic apply_reset(input bit check_now);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        q_comb.delete();
        q_wr.delete();
        if (check_now) begin
            #1;
            chk("rst_rf_we", DATA_W'(rf_we), '0);
            chk("rst_rf_waddr", DATA_W'(rf_waddr), '0);
            chk("rst_rf_wdata", rf_wdata, '0);
            chk("rst_mcu_ready", DATA_W'(mcu_ready), DATA_W'(1));
            chk("rst_pipe_stall", DATA_W'(pipe_stall), '0);
            chk("rst_mcu_hazard", DATA_W'(mcu_hazard), '0);
        end
        m_fifo.delete();
        m_starve     = 0;
        m_port       = '{we: 1'b0, addr: '0, data: '0};
        pending      = m_port;
        have_pending = 1'b1;
        pipe_valid   = 1'b0;
        mcu_valid    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic              st;
        logic              pu;
        logic              pv;
        logic [ADDR_W-1:0] prd;
        logic [DATA_W-1:0] pdata;
        rst_n      = 1'b1;
        pipe_valid = 1'b0;
        pipe_rd    = '0;
        pipe_wdata = '0;
        mcu_valid  = 1'b0;
        mcu_rd     = '0;
        mcu_wdata  = '0;
        query_rs1  = '0;
        query_rs2  = '0;
        apply_reset(1'b0);

        // Pipeline only, including an rd = 0 slot
        drive(1, 5, 32'h1234, 0, 0, 0, 0, 0, st, pu);
        drive(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, st, pu);
        drive(0, 0, 0, 0, 0, 0, 0, 0, st, pu);

        // Idle drain
        drive(0, 0, 0, 1, 7, 32'hDEAD, 0, 0, st, pu);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 7, 0, st, pu);

        // Starvation with a continuously valid pipeline
        drive(1, 1, 32'h5555, 1, 9, 32'h9999, 9, 0, st, pu);
        repeat (7) drive(1, 1, 32'h5555, 0, 0, 0, 9, 0, st, pu);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, st, pu);

        // Full back-pressure, then drain in push order
        drive(1, 2, 32'h2222, 1, 10, 32'hA0, 0, 0, st, pu);
        drive(1, 2, 32'h2222, 1, 11, 32'hA1, 11, 0, st, pu);
        for (int i = 0; i < 20; i++) begin
            drive(1, 2, 32'h2222, 1, 12, 32'hA2, 10, 12, st, pu);
            if (pu) break;
        end
        repeat (5) drive(0, 0, 0, 0, 0, 0, 12, 0, st, pu);

        // Hazard: rd = 3 matches, rd = 0 entry never matches
        drive(1, 4, 32'h4444, 1, 3, 32'h33, 0, 0, st, pu);
        drive(1, 4, 32'h4444, 1, 0, 32'h00, 3, 0, st, pu);
        drive(1, 4, 32'h4444, 0, 0, 0, 0, 0, st, pu);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 3, 0, st, pu);

        // Reset mid-stream with two queued entries
        drive(1, 1, 32'h11, 1, 3, 32'hA, 3, 0, st, pu);
        drive(1, 1, 32'h11, 1, 4, 32'hB, 3, 4, st, pu);
        apply_reset(1'b1);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 3, 4, st, pu);

        // Randomized traffic; a stalled pipeline re-presents the same writeback
        st    = 1'b0;
        pv    = 1'b0;
        prd   = '0;
        pdata = '0;
        for (int n = 0; n < 500; n++) begin
            if (!st) begin
                pv    = ($urandom_range(0, 9) < 7);
                prd   = ADDR_W'($urandom_range(0, 7));
                pdata = $urandom;
            end
            drive(pv, prd, pdata, ($urandom_range(0, 1) == 1), ADDR_W'($urandom_range(0, 7)),
                  $urandom, ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
                  st, pu);
        end

        repeat (6) drive(0, 0, 0, 0, 0, 0, 0, 0, st, pu);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback and a multi-cycle unit (MCU, e.g. divider) result stream. The pipeline writeback is the already-selected ALU / load / PC+4 value. MCU results are buffered in a small FIFO and drained in idle writeback slots. A starvation counter forces an MCU drain by stalling the pipeline for one cycle. The block also flags read-after-write hazards against MCU results that have not yet been written.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
DEPTH, 2, MCU result FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, cycles a non-empty FIFO may wait before a forced grant (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
pipe_valid  input  1  pipeline writeback valid this cycle
pipe_rd  input  ADDR_W  pipeline destination register
pipe_wdata  input  DATA_W  pipeline writeback data (ALU/load/PC+4, already muxed)
pipe_stall  output  1  combinational; pipeline must hold its writeback stage this cycle
mcu_valid  input  1  MCU result valid
mcu_ready  output  1  FIFO can accept (= !full)
mcu_rd  input  ADDR_W  MCU destination register
mcu_wdata  input  DATA_W  MCU result
query_rs1  input  ADDR_W  decode-stage source 1
query_rs2  input  ADDR_W  decode-stage source 2
mcu_hazard  output  1  combinational; a queued FIFO entry targets a nonzero queried source
rf_we  output  1  registered write enable to register file
rf_waddr  output  ADDR_W  registered write address
rf_wdata  output  DATA_W  registered write data

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, read/write pointers 0, starve_cnt 0, rf_we 0, rf_waddr 0, rf_wdata 0. Combinational outputs follow the empty state: mcu_ready 1, pipe_stall 0, mcu_hazard 0. Reset mid-operation discards all queued MCU results.
- MCU push: occurs when mcu_valid && mcu_ready. mcu_ready depends only on the full flag; there is no same-cycle pass-through when full. A pushed entry is never granted in its push cycle, so MCU-to-write-port latency is at least 2 cycles.
- Grant decision (combinational, one source per cycle):
  1. force = FIFO non-empty && starve_cnt == STARVE_LIMIT. If force, grant FIFO head; pipe_stall = pipe_valid.
  2. else if pipe_valid, grant pipeline; pipe_stall = 0.
  3. else if FIFO non-empty, grant FIFO head.
  4. else idle.
- Write port: registered, 1-cycle latency. Next cycle rf_we = granted && rd != 0, with rf_waddr/rf_wdata taken from the granted source. When idle, rf_we = 0 and rf_waddr/rf_wdata hold their values. An rd = 0 grant still consumes the slot (and pops the FIFO if FIFO-sourced) but does not write.
- Pop: the FIFO head pops on the edge after a FIFO grant. Push and pop in the same cycle are legal when not full; count is unchanged.
- starve_cnt: resets to 0 on a FIFO grant or when the FIFO is empty. Increments (saturating at STARVE_LIMIT) when the FIFO is non-empty and the pipeline is granted.
- pipe_stall: when asserted, the pipeline retains pipe_valid/pipe_rd/pipe_wdata unchanged into the next cycle. The arbiter does not latch them.
- mcu_hazard: OR over valid FIFO entries of (entry_rd != 0 && (entry_rd == query_rs1 || entry_rd == query_rs2)). The entry at the head being granted this cycle still counts. Entries being pushed this cycle are not included.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- Write ordering across sources is not enforced here. Decode uses mcu_hazard to avoid WAW/RAW conflicts.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with 2 FIFO entries queued. Outputs go to 0 immediately. After release, mcu_ready=1, mcu_hazard=0, and no stale write appears.
- Pipeline only: pipe_valid=1, rd=5, data=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234. With rd=0 -> rf_we=0.
- Idle drain: push MCU rd=7, data=0xDEAD with pipe_valid=0 -> rf_we=1, waddr=7 two cycles after the push. FIFO is then empty.
- Starvation: push MCU rd=9 and hold pipe_valid=1 continuously with STARVE_LIMIT=4. Pipeline writes for 4 cycles. On the 5th cycle pipe_stall=1 and rd=9 is written next cycle. The held pipeline value is written the cycle after that.
- Full back-pressure: fill DEPTH=2 entries while pipe_valid=1 -> mcu_ready=0. A third mcu_valid is not accepted until a pop occurs. Entries then drain in push order.
- Hazard: FIFO holds rd=3; query_rs1=3 -> mcu_hazard=1. query_rs1=0 with an entry rd=0 -> 0. Hazard clears on the cycle after the pop.
